// File: rtl/mux5_if.sv
// mux5_if: groups the mux5 data/select signals; master drives the operands, slave returns the selected word.
interface mux5_if #(parameter int size = 5);
    logic [size-1:0] in0;
    logic [size-1:0] in1;
    logic            sel;
    logic [size-1:0] out;
    modport master (output in0, in1, sel, input out);
    modport slave (input in0, in1, sel, output out);
endinterface

// File: rtl/mux5.sv
// mux5: parameterized 2:1 word multiplexer, combinational by default.
// Defining MUX5_REG_OUT_EN registers the output with one-cycle latency and sync reset to zero.
module mux5 #(parameter int size = 5) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] in0,
    input  logic [size-1:0] in1,
    input  logic            sel,
    output logic [size-1:0] out
);
    logic [size-1:0] out_d;
    assign out_d = sel ? in1 : in0;
`ifdef MUX5_REG_OUT_EN
    logic [size-1:0] out_q;
    always_ff @(posedge clk) out_q <= reset ? '0 : out_d;
    assign out = out_q;
`else
    // clk and reset only matter in the registered build
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign out = out_d;
`endif
endmodule

// File: tb/tb_mux5.sv
// tb_mux5: checks 5- and 8-bit mux5 instances against a word-array reference model, in either build.
module tb_mux5;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mux5_if #(5) a ();
    mux5_if #(8) b ();

    mux5 #(5) u5 (.clk(clk), .reset(reset), .in0(a.in0), .in1(a.in1), .sel(a.sel), .out(a.out));
    mux5 #(8) u8 (.clk(clk), .reset(reset), .in0(b.in0), .in1(b.in1), .sel(b.sel), .out(b.out));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp5_q = '0;
    logic [7:0] exp8_q = '0;
    bit valid_q = 1'b0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pick(input logic [7:0] x0, input logic [7:0] x1, input logic s);
        logic [7:0] words [2];
        words[0] = x0;
        words[1] = x1;
        return words[s ? 1 : 0];
    endfunction

    task automatic step(input string tag, input logic [4:0] x0, input logic [4:0] x1, input logic s5,
                        input logic [7:0] y0, input logic [7:0] y1, input logic s8, input logic r);
        logic [7:0] e5;
        logic [7:0] e8;
        @(negedge clk);
        reset = r;
        a.in0 = x0; a.in1 = x1; a.sel = s5;
        b.in0 = y0; b.in1 = y1; b.sel = s8;
        e5 = pick({3'b0, x0}, {3'b0, x1}, s5);
        e8 = pick(y0, y1, s8);
`ifdef MUX5_REG_OUT_EN
        #1;
        if (valid_q) begin
            chk({tag, "/hold5"}, {3'b0, a.out}, exp5_q);
            chk({tag, "/hold8"}, b.out, exp8_q);
        end
        @(posedge clk);
        #1;
        if (r) begin
            e5 = '0;
            e8 = '0;
        end
`else
        #1;
`endif
        chk({tag, "/w5"}, {3'b0, a.out}, e5);
        chk({tag, "/w8"}, b.out, e8);
        exp5_q = e5;
        exp8_q = e8;
        valid_q = 1'b1;
    endtask

    initial begin
        a.in0 = '0; a.in1 = '0; a.sel = 1'b0;
        b.in0 = '0; b.in1 = '0; b.sel = 1'b0;
        step("reset", 5'd0, 5'd12, 1'b1, 8'hA5, 8'h5A, 1'b0, 1'b1);
        step("post_reset", 5'd0, 5'd12, 1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0);
        step("sel0", 5'd0, 5'd12, 1'b0, 8'hA5, 8'h5A, 1'b0, 1'b0);
        step("sel1", 5'd0, 5'd12, 1'b1, 8'hA5, 8'h5A, 1'b1, 1'b0);
        step("all_ones", 5'b11111, 5'd12, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
        step("all_ones_in1", 5'd3, 5'b11111, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            step("alt_a5_5a", 5'd7, 5'd24, i[0], 8'hA5, 8'h5A, i[0], 1'b0);
        step("sel_and_data", 5'd9, 5'd22, 1'b0, 8'h11, 8'hEE, 1'b1, 1'b0);
        step("reset_mid", 5'd9, 5'd22, 1'b1, 8'h11, 8'hEE, 1'b0, 1'b1);
        step("resume", 5'd9, 5'd22, 1'b1, 8'h11, 8'hEE, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++)
            step("rand", 5'($urandom), 5'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), ($urandom_range(0, 9) == 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
